// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data main-memory arbiter.
package arbiter_defs;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    INS  = 1'b0,
    DATA = 1'b1
  } requester_t;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main memory between the instruction and data caches.
module mem_arbiter
  import arbiter_defs::*;
#(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              INS_MEM_READ,
  input  logic [ADDR_W-1:0] INS_MEM_ADDRESS,
  output logic [LINE_W-1:0] INS_MEM_READ_DATA,
  output logic              INS_MEM_BUSY_WAIT,
  input  logic              DATA_MEM_READ,
  input  logic              DATA_MEM_WRITE,
  input  logic [ADDR_W-1:0] DATA_MEM_ADDRESS,
  input  logic [LINE_W-1:0] DATA_MEM_WRITE_DATA,
  output logic [LINE_W-1:0] DATA_MEM_READ_DATA,
  output logic              DATA_MEM_BUSY_WAIT,
  output logic              MAIN_MEM_READ,
  output logic              MAIN_MEM_WRITE,
  output logic [ADDR_W-1:0] MAIN_MEM_ADDRESS,
  output logic [LINE_W-1:0] MAIN_MEM_WRITE_DATA,
  input  logic [LINE_W-1:0] MAIN_MEM_READ_DATA,
  input  logic              MAIN_MEM_BUSY_WAIT
);

  arb_state_t state;
  requester_t last;
  logic       started;
  logic       ins_req;
  logic       data_req;
  logic       granted_req;

  assign ins_req     = INS_MEM_READ;
  assign data_req    = DATA_MEM_READ | DATA_MEM_WRITE;
  assign granted_req = (state == GRANT_I) ? ins_req : data_req;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= IDLE;
      last    <= INS;
      started <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          started <= 1'b0;
          if (ins_req && data_req) begin
            // Tie: the side that did not win the previous tie goes first.
            if (last == INS) begin
              state <= GRANT_D;
              last  <= DATA;
            end else begin
              state <= GRANT_I;
              last  <= INS;
            end
          end else if (ins_req) begin
            state <= GRANT_I;
          end else if (data_req) begin
            state <= GRANT_D;
          end
        end
        GRANT_I, GRANT_D: begin
          if (started && !MAIN_MEM_BUSY_WAIT) begin
            state   <= DONE;
            started <= 1'b0;
          end else if (!started && !granted_req) begin
            state <= IDLE;
          end else if (MAIN_MEM_BUSY_WAIT) begin
            started <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          started <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    MAIN_MEM_READ       = 1'b0;
    MAIN_MEM_WRITE      = 1'b0;
    MAIN_MEM_ADDRESS    = '0;
    MAIN_MEM_WRITE_DATA = '0;
    INS_MEM_BUSY_WAIT   = ins_req;
    DATA_MEM_BUSY_WAIT  = data_req;
    case (state)
      GRANT_I: begin
        MAIN_MEM_READ     = INS_MEM_READ;
        MAIN_MEM_ADDRESS  = INS_MEM_ADDRESS;
        // Hold the cache stalled until memory has actually picked up the request.
        INS_MEM_BUSY_WAIT = started ? MAIN_MEM_BUSY_WAIT : 1'b1;
      end
      GRANT_D: begin
        MAIN_MEM_READ       = DATA_MEM_READ;
        MAIN_MEM_WRITE      = DATA_MEM_WRITE;
        MAIN_MEM_ADDRESS    = DATA_MEM_ADDRESS;
        MAIN_MEM_WRITE_DATA = DATA_MEM_WRITE_DATA;
        DATA_MEM_BUSY_WAIT  = started ? MAIN_MEM_BUSY_WAIT : 1'b1;
      end
      default: ;
    endcase
  end

  assign INS_MEM_READ_DATA  = MAIN_MEM_READ_DATA;
  assign DATA_MEM_READ_DATA = MAIN_MEM_READ_DATA;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle model of the arbitration rules, a latency-5 memory and two cache agents.
module tb_mem_arbiter;

  localparam int ADDR_W = 28;
  localparam int LINE_W = 128;
  localparam int LAT    = 5;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              INS_MEM_READ;
  logic [ADDR_W-1:0] INS_MEM_ADDRESS;
  logic [LINE_W-1:0] INS_MEM_READ_DATA;
  logic              INS_MEM_BUSY_WAIT;
  logic              DATA_MEM_READ;
  logic              DATA_MEM_WRITE;
  logic [ADDR_W-1:0] DATA_MEM_ADDRESS;
  logic [LINE_W-1:0] DATA_MEM_WRITE_DATA;
  logic [LINE_W-1:0] DATA_MEM_READ_DATA;
  logic              DATA_MEM_BUSY_WAIT;
  logic              MAIN_MEM_READ;
  logic              MAIN_MEM_WRITE;
  logic [ADDR_W-1:0] MAIN_MEM_ADDRESS;
  logic [LINE_W-1:0] MAIN_MEM_WRITE_DATA;
  logic [LINE_W-1:0] MAIN_MEM_READ_DATA;
  logic              MAIN_MEM_BUSY_WAIT;

  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .INS_MEM_READ        (INS_MEM_READ),
    .INS_MEM_ADDRESS     (INS_MEM_ADDRESS),
    .INS_MEM_READ_DATA   (INS_MEM_READ_DATA),
    .INS_MEM_BUSY_WAIT   (INS_MEM_BUSY_WAIT),
    .DATA_MEM_READ       (DATA_MEM_READ),
    .DATA_MEM_WRITE      (DATA_MEM_WRITE),
    .DATA_MEM_ADDRESS    (DATA_MEM_ADDRESS),
    .DATA_MEM_WRITE_DATA (DATA_MEM_WRITE_DATA),
    .DATA_MEM_READ_DATA  (DATA_MEM_READ_DATA),
    .DATA_MEM_BUSY_WAIT  (DATA_MEM_BUSY_WAIT),
    .MAIN_MEM_READ       (MAIN_MEM_READ),
    .MAIN_MEM_WRITE      (MAIN_MEM_WRITE),
    .MAIN_MEM_ADDRESS    (MAIN_MEM_ADDRESS),
    .MAIN_MEM_WRITE_DATA (MAIN_MEM_WRITE_DATA),
    .MAIN_MEM_READ_DATA  (MAIN_MEM_READ_DATA),
    .MAIN_MEM_BUSY_WAIT  (MAIN_MEM_BUSY_WAIT)
  );

  function automatic logic [LINE_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    w = 32'hA5A5_0000 ^ 32'(a);
    return {4{w}};
  endfunction

  // Main memory: accepts a request, stays busy LAT cycles, then waits for the request to drop.
  int                unsigned mphase;
  int                unsigned mcnt;
  int                unsigned acc_cnt;
  logic              m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wd;
  logic [ADDR_W-1:0] wr_addr;
  logic [LINE_W-1:0] wr_data;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mphase             <= 0;
      mcnt               <= 0;
      acc_cnt            <= 0;
      m_wr               <= 1'b0;
      m_addr             <= '0;
      m_wd               <= '0;
      wr_addr            <= '0;
      wr_data            <= '0;
      MAIN_MEM_BUSY_WAIT <= 1'b0;
      MAIN_MEM_READ_DATA <= '0;
    end else begin
      case (mphase)
        0: if (MAIN_MEM_READ || MAIN_MEM_WRITE) begin
          MAIN_MEM_BUSY_WAIT <= 1'b1;
          mcnt    <= LAT - 1;
          mphase  <= 1;
          m_addr  <= MAIN_MEM_ADDRESS;
          m_wr    <= MAIN_MEM_WRITE;
          m_wd    <= MAIN_MEM_WRITE_DATA;
          acc_cnt <= acc_cnt + 1;
        end
        1: if (mcnt == 0) begin
          MAIN_MEM_BUSY_WAIT <= 1'b0;
          mphase <= 2;
          if (m_wr) begin
            wr_addr <= m_addr;
            wr_data <= m_wd;
          end else begin
            MAIN_MEM_READ_DATA <= pattern(m_addr);
          end
        end else begin
          mcnt <= mcnt - 1;
        end
        default: if (!MAIN_MEM_READ && !MAIN_MEM_WRITE) mphase <= 0;
      endcase
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    check(name, LINE_W'(act), LINE_W'(exp));
  endtask

  // Behavioural model: who owns memory, whether memory has accepted, the one-cycle gap, tie preference.
  int   m_owner;    // 0 none, 1 instruction, 2 data
  logic m_seen;
  logic m_gap;
  logic m_tie_data;

  task automatic model_reset();
    m_owner    = 0;
    m_seen     = 1'b0;
    m_gap      = 1'b0;
    m_tie_data = 1'b1;
  endtask

  task automatic model_compare();
    logic              ireq, dreq, e_rd, e_wr, e_ib, e_db;
    logic [ADDR_W-1:0] e_addr;
    logic [LINE_W-1:0] e_wd;
    if (!RESET) model_reset();
    ireq   = INS_MEM_READ;
    dreq   = DATA_MEM_READ | DATA_MEM_WRITE;
    e_rd   = 1'b0;
    e_wr   = 1'b0;
    e_addr = '0;
    e_wd   = '0;
    e_ib   = ireq;
    e_db   = dreq;
    if (m_owner == 1) begin
      e_rd   = INS_MEM_READ;
      e_addr = INS_MEM_ADDRESS;
      e_ib   = m_seen ? MAIN_MEM_BUSY_WAIT : 1'b1;
    end else if (m_owner == 2) begin
      e_rd   = DATA_MEM_READ;
      e_wr   = DATA_MEM_WRITE;
      e_addr = DATA_MEM_ADDRESS;
      e_wd   = DATA_MEM_WRITE_DATA;
      e_db   = m_seen ? MAIN_MEM_BUSY_WAIT : 1'b1;
    end
    chk_bit("main_read", MAIN_MEM_READ, e_rd);
    chk_bit("main_write", MAIN_MEM_WRITE, e_wr);
    check("main_addr", LINE_W'(MAIN_MEM_ADDRESS), LINE_W'(e_addr));
    check("main_wdata", MAIN_MEM_WRITE_DATA, e_wd);
    chk_bit("ins_busy", INS_MEM_BUSY_WAIT, e_ib);
    chk_bit("data_busy", DATA_MEM_BUSY_WAIT, e_db);
    check("ins_rdata", INS_MEM_READ_DATA, MAIN_MEM_READ_DATA);
    check("data_rdata", DATA_MEM_READ_DATA, MAIN_MEM_READ_DATA);
  endtask

  task automatic model_step();
    logic ireq, dreq, greq;
    if (!RESET) begin
      model_reset();
      return;
    end
    ireq = INS_MEM_READ;
    dreq = DATA_MEM_READ | DATA_MEM_WRITE;
    if (m_gap) begin
      m_gap = 1'b0;
    end else if (m_owner == 0) begin
      if (ireq && dreq) begin
        m_owner    = m_tie_data ? 2 : 1;
        m_tie_data = !m_tie_data;
      end else if (ireq) begin
        m_owner = 1;
      end else if (dreq) begin
        m_owner = 2;
      end
    end else begin
      greq = (m_owner == 1) ? ireq : dreq;
      if (m_seen && !MAIN_MEM_BUSY_WAIT) begin
        m_owner = 0;
        m_seen  = 1'b0;
        m_gap   = 1'b1;
      end else if (!m_seen && !greq) begin
        m_owner = 0;
      end else if (MAIN_MEM_BUSY_WAIT) begin
        m_seen = 1'b1;
      end
    end
  endtask

  // Cache agents: hold a request until its busy line is seen low, then log the completion.
  logic              ins_act, data_act;
  int                ins_left, data_left;
  int                order[$];
  logic [LINE_W-1:0] ins_got;
  logic [ADDR_W-1:0] ins_base, data_base;

  task automatic raise_ins(input logic [ADDR_W-1:0] a);
    ins_act         = 1'b1;
    INS_MEM_READ    = 1'b1;
    INS_MEM_ADDRESS = a;
  endtask

  task automatic raise_data(input logic wr, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] wd);
    data_act            = 1'b1;
    DATA_MEM_READ       = !wr;
    DATA_MEM_WRITE      = wr;
    DATA_MEM_ADDRESS    = a;
    DATA_MEM_WRITE_DATA = wd;
  endtask

  task automatic drop_all();
    ins_act        = 1'b0;
    data_act       = 1'b0;
    ins_left       = 0;
    data_left      = 0;
    INS_MEM_READ   = 1'b0;
    DATA_MEM_READ  = 1'b0;
    DATA_MEM_WRITE = 1'b0;
  endtask

  task automatic tick();
    logic              ib, db;
    logic [LINE_W-1:0] ird;
    @(negedge CLK);
    model_compare();
    ib  = INS_MEM_BUSY_WAIT;
    db  = DATA_MEM_BUSY_WAIT;
    ird = INS_MEM_READ_DATA;
    @(posedge CLK);
    model_step();
    #1;
    if (ins_act && !ib) begin
      ins_act      = 1'b0;
      INS_MEM_READ = 1'b0;
      ins_got      = ird;
      order.push_back(0);
    end
    if (data_act && !db) begin
      data_act       = 1'b0;
      DATA_MEM_READ  = 1'b0;
      DATA_MEM_WRITE = 1'b0;
      order.push_back(1);
    end
    if (!ins_act && ins_left > 0) begin
      ins_left--;
      ins_base = ins_base + 28'd1;
      raise_ins(ins_base);
    end
    if (!data_act && data_left > 0) begin
      data_left--;
      data_base = data_base + 28'd1;
      raise_data(1'b0, data_base, '0);
    end
  endtask

  task automatic run_until(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (order.size() < n && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (order.size() < n) begin
      failures++;
      $display("FAIL %s timeout: completions %0d expected %0d", name, order.size(), n);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    drop_all();
    order.delete();
    tick();
    tick();
    RESET = 1'b1;
    tick();
  endtask

  function automatic logic [7:0] order_bits();
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < order.size() && i < 8; i++) b[i] = order[i][0];
    return b;
  endfunction

  initial begin
    int n;
    int unsigned acc0;
    RESET               = 1'b0;
    INS_MEM_ADDRESS     = '0;
    DATA_MEM_ADDRESS    = '0;
    DATA_MEM_WRITE_DATA = '0;
    ins_got             = '0;
    ins_base            = '0;
    data_base           = '0;
    drop_all();
    model_reset();

    // Reset state
    tick();
    chk_bit("rst_main_read", MAIN_MEM_READ, 1'b0);
    chk_bit("rst_main_write", MAIN_MEM_WRITE, 1'b0);
    check("rst_main_addr", LINE_W'(MAIN_MEM_ADDRESS), '0);
    chk_bit("rst_ins_busy_idle", INS_MEM_BUSY_WAIT, 1'b0);
    INS_MEM_READ = 1'b1;
    #1;
    chk_bit("rst_ins_busy_req", INS_MEM_BUSY_WAIT, 1'b1);
    do_reset();

    // Instruction-only read of block 0x10
    raise_ins(28'h0000010);
    #1;
    chk_bit("t1_not_yet_forwarded", MAIN_MEM_READ, 1'b0);
    tick();
    chk_bit("t1_main_read_cycle1", MAIN_MEM_READ, 1'b1);
    check("t1_main_addr", LINE_W'(MAIN_MEM_ADDRESS), LINE_W'(28'h0000010));
    n = 1;
    while (order.size() < 1 && n < 40) begin
      tick();
      n++;
    end
    check("t1_cycles_to_complete", LINE_W'(n), LINE_W'(8));
    check("t1_ins_rdata", ins_got, 128'hA5A50010_A5A50010_A5A50010_A5A50010);
    tick();
    tick();

    // Data write-back to block 0x20
    do_reset();
    raise_data(1'b1, 28'h0000020, {4{32'hDEADBEEF}});
    tick();
    chk_bit("t2_main_write", MAIN_MEM_WRITE, 1'b1);
    check("t2_main_addr", LINE_W'(MAIN_MEM_ADDRESS), LINE_W'(28'h0000020));
    check("t2_main_wdata", MAIN_MEM_WRITE_DATA, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);
    run_until(1, 40, "t2_write");
    chk_bit("t2_done_no_write", MAIN_MEM_WRITE, 1'b0);
    check("t2_mem_wr_addr", LINE_W'(wr_addr), LINE_W'(28'h0000020));
    check("t2_mem_wr_data", wr_data, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);
    tick();
    tick();

    // Simultaneous requests after reset: data first, instruction right after
    do_reset();
    raise_ins(28'h0000090);
    raise_data(1'b0, 28'h00000A0, '0);
    tick();
    check("t3_first_grant_addr", LINE_W'(MAIN_MEM_ADDRESS), LINE_W'(28'h00000A0));
    run_until(1, 40, "t3_data");
    check("t3_first_done", LINE_W'(order_bits()), LINE_W'(8'b0000_0001));
    tick();
    chk_bit("t3_idle_gap", MAIN_MEM_READ, 1'b0);
    tick();
    chk_bit("t3_ins_granted", MAIN_MEM_READ, 1'b1);
    check("t3_ins_addr", LINE_W'(MAIN_MEM_ADDRESS), LINE_W'(28'h0000090));
    run_until(2, 40, "t3_ins");

    // Six back-to-back transfers with both sides always requesting
    do_reset();
    ins_base  = 28'h0000100;
    data_base = 28'h0000200;
    raise_ins(ins_base);
    raise_data(1'b0, data_base, '0);
    ins_left  = 2;
    data_left = 2;
    run_until(6, 200, "t4_alternate");
    check("t4_count", LINE_W'(order.size()), LINE_W'(6));
    check("t4_order", LINE_W'(order_bits()), LINE_W'(8'b0001_0101));
    tick();
    tick();

    // Data drops its read before memory picks it up: abort, instruction goes next
    do_reset();
    acc0 = acc_cnt;
    raise_ins(28'h0000040);
    raise_data(1'b0, 28'h0000050, '0);
    tick();
    check("t5_data_granted", LINE_W'(MAIN_MEM_ADDRESS), LINE_W'(28'h0000050));
    data_act      = 1'b0;
    DATA_MEM_READ = 1'b0;
    tick();
    chk_bit("t5_abort_idle", MAIN_MEM_READ, 1'b0);
    tick();
    chk_bit("t5_ins_read", MAIN_MEM_READ, 1'b1);
    check("t5_ins_addr", LINE_W'(MAIN_MEM_ADDRESS), LINE_W'(28'h0000040));
    run_until(1, 40, "t5_ins");
    check("t5_mem_accepts", LINE_W'(acc_cnt - acc0), LINE_W'(1));
    tick();
    tick();

    // Reset in the middle of a data transfer
    do_reset();
    raise_data(1'b0, 28'h0000060, '0);
    repeat (4) tick();
    chk_bit("t6_in_transfer", MAIN_MEM_READ, 1'b1);
    RESET = 1'b0;
    #1;
    chk_bit("t6_rst_read", MAIN_MEM_READ, 1'b0);
    chk_bit("t6_rst_write", MAIN_MEM_WRITE, 1'b0);
    check("t6_rst_addr", LINE_W'(MAIN_MEM_ADDRESS), '0);
    drop_all();
    order.delete();
    tick();
    RESET = 1'b1;
    tick();
    raise_ins(28'h0000070);
    raise_data(1'b0, 28'h0000080, '0);
    tick();
    check("t6_tie_grants_data", LINE_W'(MAIN_MEM_ADDRESS), LINE_W'(28'h0000080));
    run_until(2, 60, "t6_both");
    check("t6_order", LINE_W'(order_bits()), LINE_W'(8'b0000_0001));
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
